bit_pixel_writer: RTL and testbench
===================================

// Module: bit_pixel_writer
// PURPOSE
//  Upstream producer for the bit-pixel RAMs. Takes a raster of 8-bit greyscale pixels
//  (3*third_width x third_height), thresholds each pixel to 1 bit and packs 8 pixels per byte.
//  Writes each third of the row into its own RAM (left/centerleft/right) at {buf_index, addr}.
//  On frame completion, toggles buf_index and increments image_number for the reader stage.
// PARAMETERS
//  third_width   240  pixels per third per row; must be a multiple of 8
//  third_height  480  rows per frame
// PORTS
//  pclk               in   1   pixel clock
//  pclk_reset_n       in   1   asynchronous active-low reset
//  pix_data           in   8   greyscale pixel
//  pix_valid          in   1   pix_data valid
//  pix_sof            in   1   qualifies the first pixel of a frame (sampled with pix_valid)
//  pix_ready          out  1   pixel accepted when pix_valid & pix_ready
//  threshold          in   8   binarisation level; quasi-static, sampled at SOF
//  wr_address         out  16  {buf_index, 15-bit byte address}, shared by all three RAMs
//  wr_data            out  8   packed byte; bit 7 = leftmost pixel of the group
//  wr_en_left         out  1   write strobe, left RAM
//  wr_en_centerleft   out  1   write strobe, centerleft RAM
//  wr_en_right        out  1   write strobe, right RAM
//  image_number       out  4   completed-frame counter consumed by the reader
//  frame_error        out  1   sticky framing error (BIT_PIXEL_WRITER_CHECK_EN only)
// BEHAVIOUR
//  Reset: all outputs 0, state ST_WAIT_SOF, buf_index 0, counters 0, threshold_reg 0.
//  Binarise: bit = (pix_data >= threshold_reg); unsigned 8-bit compare.
//  ST_WAIT_SOF: pix_ready=1. Pixels without pix_sof are dropped. A pixel with pix_sof:
//   latch threshold, clear counters, process it as column 0 / row 0 -> ST_ACTIVE.
//  ST_ACTIVE: pix_ready=1. Each accepted pixel shifts into an 8-bit pack register.
//   col_in_third 0..third_width-1, third_index 0..2, row 0..third_height-1.
//  Write issue: the 8th pixel of a group is accepted at cycle N. At N+1, exactly one wr_en_*
//   pulses for 1 cycle (selected by third_index), with wr_data and wr_address valid.
//   Address = row*(third_width/8) + col_in_third/8. Computed incrementally with a row-base
//   register; no multiplier.
//   Other cycles: wr_en_* = 0. wr_address/wr_data hold their last value.
//  Wrap: at col_in_third end -> third_index+1. At third 2 end -> row+1, third_index 0.
//  Last pixel of the frame (row=third_height-1, third 2, last column) -> ST_COMMIT.
//  ST_COMMIT (1 cycle): pix_ready=0. The final byte write occurs in this cycle.
//   On exit: buf_index toggles and image_number increments (15 -> 0 wrap).
//   image_number changes at N+2 relative to the last pixel at N, i.e. after the last write.
//   Then -> ST_WAIT_SOF.
//  pix_sof in ST_ACTIVE (short frame): discard the partial pack register.
//   Restart at row 0 / column 0 in the same buffer. No commit, no image_number change.
//  pix_sof on the final pixel of a frame: treated as SOF of a new frame (previous not committed).
//  Async reset mid-frame: partial frame is lost. The reader must also be reset, since
//   buf_index/image_number restart at 0.
//  Throughput: 1 pixel/clk except 1 stall cycle per frame (ST_COMMIT).
// CONFIGURATION
//  BIT_PIXEL_WRITER_CHECK_EN defined:
//   frame_error sets (sticky until reset) on pix_sof in ST_ACTIVE.
//   It also sets if pix_sof is absent while ST_ACTIVE expects column 0 of row 0.
//  BIT_PIXEL_WRITER_CHECK_EN undefined: frame_error tied 0, no extra logic.
// TESTING
//  - Reset, then full frame with all pix_data=0x80, threshold=0x80 -> 3*14400 writes, all
//    wr_data=0xFF; last address 0x383F; image_number 0->1; buf_index 0->1.
//  - Row 0 pixels alternating 0x00/0xFF, threshold 0x01 -> first byte 0x55 at {0,0x0000}
//    on wr_en_left; first centerleft write at addr 0x0000 after 240 pixels.
//  - Two back-to-back frames -> second frame addresses have bit 15 = 1; image_number = 2.
//  - pix_sof reinserted after 1000 pixels -> no image_number change; next full frame writes
//    buf 0 from addr 0; CHECK_EN build: frame_error=1.
//  - Reset asserted mid-frame -> outputs 0 immediately (async); pixels before SOF dropped.
//  - 16 complete frames -> image_number wraps 15 -> 0; buf_index back to 0.

Source files
------------

// File: rtl/bit_pixel_writer.sv
// Thresholds a 3-third greyscale raster to 1 bit/pixel and packs 8 pixels per byte into three RAMs.
// Optional framing checker enabled by defining BIT_PIXEL_WRITER_CHECK_EN.
module bit_pixel_writer #(
    parameter int third_width  = 240,
    parameter int third_height = 480
) (
    input  logic        pclk,
    input  logic        pclk_reset_n,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic [7:0]  threshold,
    output logic [15:0] wr_address,
    output logic [7:0]  wr_data,
    output logic        wr_en_left,
    output logic        wr_en_centerleft,
    output logic        wr_en_right,
    output logic [3:0]  image_number,
    output logic        frame_error
);

    localparam int col_w = $clog2(third_width);
    localparam int row_w = $clog2(third_height);
    localparam logic [col_w-1:0] col_max  = col_w'(third_width - 1);
    localparam logic [row_w-1:0] row_max  = row_w'(third_height - 1);
    localparam logic [14:0]      row_step = 15'(third_width / 8);

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COMMIT   = 2'd2
    } state_t;

    state_t           state_r;
    logic [7:0]       threshold_reg_r;
    logic [col_w-1:0] col_r;
    logic [1:0]       third_r;
    logic [row_w-1:0] row_r;
    logic [14:0]      base_r;
    logic [6:0]       pack_r;
    logic             buf_index_r;
    logic [3:0]       image_number_r;
    logic             pix_ready_r;
    logic             wr_en_left_r;
    logic             wr_en_centerleft_r;
    logic             wr_en_right_r;
    logic [15:0]      wr_address_r;
    logic [7:0]       wr_data_r;

    logic             take_s;
    logic [7:0]       cur_thr_s;
    logic [col_w-1:0] cur_col_s;
    logic [1:0]       cur_third_s;
    logic [row_w-1:0] cur_row_s;
    logic [14:0]      cur_base_s;
    logic [6:0]       cur_pack_s;
    logic             bit_s;
    logic             col_last_s;
    logic             third_last_s;
    logic             group_end_s;
    logic             frame_end_s;
    logic [col_w-1:0] next_col_s;
    logic [1:0]       next_third_s;
    logic [row_w-1:0] next_row_s;
    logic [14:0]      next_base_s;
    logic [14:0]      addr_s;

    // Position of the pixel being taken: a SOF pixel always counts as column 0 / row 0.
    always_comb begin
        take_s = pix_valid & pix_ready_r & ((state_r == ST_ACTIVE) | pix_sof);
        if (pix_sof) begin
            cur_thr_s   = threshold;
            cur_col_s   = '0;
            cur_third_s = 2'd0;
            cur_row_s   = '0;
            cur_base_s  = 15'd0;
            cur_pack_s  = 7'd0;
        end else begin
            cur_thr_s   = threshold_reg_r;
            cur_col_s   = col_r;
            cur_third_s = third_r;
            cur_row_s   = row_r;
            cur_base_s  = base_r;
            cur_pack_s  = pack_r;
        end
        bit_s        = (pix_data >= cur_thr_s);
        col_last_s   = (cur_col_s == col_max);
        third_last_s = (cur_third_s == 2'd2);
        group_end_s  = (cur_col_s[2:0] == 3'd7);
        frame_end_s  = col_last_s & third_last_s & (cur_row_s == row_max);
        addr_s       = cur_base_s + 15'(cur_col_s >> 3);
        if (col_last_s) begin
            next_col_s   = '0;
            next_third_s = third_last_s ? 2'd0 : cur_third_s + 2'd1;
        end else begin
            next_col_s   = cur_col_s + col_w'(1);
            next_third_s = cur_third_s;
        end
        if (col_last_s & third_last_s) begin
            next_row_s  = cur_row_s + row_w'(1);
            next_base_s = cur_base_s + row_step;
        end else begin
            next_row_s  = cur_row_s;
            next_base_s = cur_base_s;
        end
    end

    // Frame FSM, pixel packing and registered RAM write port.
    always_ff @(posedge pclk or negedge pclk_reset_n) begin
        if (!pclk_reset_n) begin
            state_r            <= ST_WAIT_SOF;
            threshold_reg_r    <= 8'd0;
            col_r              <= '0;
            third_r            <= 2'd0;
            row_r              <= '0;
            base_r             <= 15'd0;
            pack_r             <= 7'd0;
            buf_index_r        <= 1'b0;
            image_number_r     <= 4'd0;
            pix_ready_r        <= 1'b0;
            wr_en_left_r       <= 1'b0;
            wr_en_centerleft_r <= 1'b0;
            wr_en_right_r      <= 1'b0;
            wr_address_r       <= 16'd0;
            wr_data_r          <= 8'd0;
        end else begin
            wr_en_left_r       <= 1'b0;
            wr_en_centerleft_r <= 1'b0;
            wr_en_right_r      <= 1'b0;
            case (state_r)
                ST_WAIT_SOF, ST_ACTIVE: begin
                    pix_ready_r <= 1'b1;
                    if (take_s) begin
                        col_r   <= next_col_s;
                        third_r <= next_third_s;
                        row_r   <= next_row_s;
                        base_r  <= next_base_s;
                        pack_r  <= {cur_pack_s[5:0], bit_s};
                        if (pix_sof) begin
                            threshold_reg_r <= threshold;
                        end
                        if (group_end_s) begin
                            wr_data_r    <= {cur_pack_s, bit_s};
                            wr_address_r <= {buf_index_r, addr_s};
                            case (cur_third_s)
                                2'd0:    wr_en_left_r       <= 1'b1;
                                2'd1:    wr_en_centerleft_r <= 1'b1;
                                2'd2:    wr_en_right_r      <= 1'b1;
                                default: wr_en_left_r       <= 1'b0;
                            endcase
                        end
                        if (frame_end_s) begin
                            state_r     <= ST_COMMIT;
                            pix_ready_r <= 1'b0;
                        end else begin
                            state_r <= ST_ACTIVE;
                        end
                    end
                end
                ST_COMMIT: begin
                    buf_index_r    <= ~buf_index_r;
                    image_number_r <= image_number_r + 4'd1;
                    pix_ready_r    <= 1'b1;
                    state_r        <= ST_WAIT_SOF;
                end
                default: begin
                    pix_ready_r <= 1'b0;
                    state_r     <= ST_WAIT_SOF;
                end
            endcase
        end
    end

    assign pix_ready        = pix_ready_r;
    assign wr_address       = wr_address_r;
    assign wr_data          = wr_data_r;
    assign wr_en_left       = wr_en_left_r;
    assign wr_en_centerleft = wr_en_centerleft_r;
    assign wr_en_right      = wr_en_right_r;
    assign image_number     = image_number_r;

`ifdef BIT_PIXEL_WRITER_CHECK_EN
    logic frame_error_r;

    // Sticky flag: SOF inside a frame, or a frame start that arrives without SOF.
    always_ff @(posedge pclk or negedge pclk_reset_n) begin
        if (!pclk_reset_n) begin
            frame_error_r <= 1'b0;
        end else if (pix_valid & pix_ready_r & (state_r == ST_ACTIVE) &
                     (pix_sof | ((col_r == '0) & (third_r == 2'd0) & (row_r == '0)))) begin
            frame_error_r <= 1'b1;
        end else begin
            frame_error_r <= frame_error_r;
        end
    end

    assign frame_error = frame_error_r;
`else
    assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_bit_pixel_writer.sv
// Directed self-checking bench for bit_pixel_writer on a reduced 3x16 x 4 raster.
module tb_bit_pixel_writer;

    localparam int tw       = 16;
    localparam int th       = 4;
    localparam int frame_px = 3 * tw * th;
`ifdef BIT_PIXEL_WRITER_CHECK_EN
    localparam logic exp_ferr = 1'b1;
`else
    localparam logic exp_ferr = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        pclk_reset_n = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_ready;
    logic [7:0]  threshold = 8'd0;
    logic [15:0] wr_address;
    logic [7:0]  wr_data;
    logic        wr_en_left;
    logic        wr_en_centerleft;
    logic        wr_en_right;
    logic [3:0]  image_number;
    logic        frame_error;

    typedef struct {
        logic [2:0]  en;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] exp_byte = 8'h00;
    int         bad_cnt = 0;
    int         multi_cnt = 0;
    int         errors = 0;
    int         checks = 0;
    int         q_base;

    bit_pixel_writer #(.third_width(tw), .third_height(th)) dut (
        .pclk             (pclk),
        .pclk_reset_n     (pclk_reset_n),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_sof          (pix_sof),
        .pix_ready        (pix_ready),
        .threshold        (threshold),
        .wr_address       (wr_address),
        .wr_data          (wr_data),
        .wr_en_left       (wr_en_left),
        .wr_en_centerleft (wr_en_centerleft),
        .wr_en_right      (wr_en_right),
        .image_number     (image_number),
        .frame_error      (frame_error)
    );

    always #5 pclk = ~pclk;

    // Log every RAM write mid-cycle and compare its byte to the expected fill.
    always @(negedge pclk) begin
        if (wr_en_left | wr_en_centerleft | wr_en_right) begin
            wr_q.push_back('{en: {wr_en_right, wr_en_centerleft, wr_en_left},
                             addr: wr_address, data: wr_data});
            if (wr_data !== exp_byte) bad_cnt++;
            if ((32'(wr_en_left) + 32'(wr_en_centerleft) + 32'(wr_en_right)) > 1) multi_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic sof);
        int n;
        @(negedge pclk);
        n = 0;
        while (pix_ready !== 1'b1 && n < 8) begin
            @(negedge pclk);
            n++;
        end
        check("pix_ready_wait", 32'(pix_ready), 32'd1);
        pix_data  = d;
        pix_sof   = sof;
        pix_valid = 1'b1;
        @(posedge pclk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    // Threshold is flipped after the SOF pixel to show it was latched at SOF.
    task automatic send(input int count, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] thr, input logic first_sof);
        threshold = thr;
        for (int i = 0; i < count; i++) begin
            push((i % 2 == 1) ? d1 : d0, first_sof && (i == 0));
            if (i == 0) threshold = ~thr;
        end
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_ready", 32'(pix_ready), 32'd0);
        check("rst_en_l", 32'(wr_en_left), 32'd0);
        check("rst_en_c", 32'(wr_en_centerleft), 32'd0);
        check("rst_en_r", 32'(wr_en_right), 32'd0);
        check("rst_addr", 32'(wr_address), 32'h0);
        check("rst_data", 32'(wr_data), 32'h0);
        check("rst_img", 32'(image_number), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        @(negedge pclk);
        pclk_reset_n = 1'b1;

        // Frame A: 0x80 at threshold 0x80 -> all ones, buffer 0
        exp_byte = 8'hFF;
        q_base = wr_q.size();
        send(frame_px, 8'h80, 8'h80, 8'h80, 1'b1);
        check("a_last_en_r", 32'(wr_en_right), 32'd1);
        check("a_last_addr", 32'(wr_address), 32'h0007);
        check("a_last_data", 32'(wr_data), 32'hFF);
        check("a_commit_ready", 32'(pix_ready), 32'd0);
        check("a_commit_img", 32'(image_number), 32'd0);
        tick();
        check("a_img", 32'(image_number), 32'd1);
        check("a_en_clear", 32'(wr_en_right), 32'd0);
        check("a_ready_back", 32'(pix_ready), 32'd1);
        check("a_count", 32'(wr_q.size() - q_base), 32'd24);
        check("a_first_addr", 32'(wr_q[q_base].addr), 32'h0000);

        // Frame B: alternating 0x00/0xFF at threshold 0x01 -> 0x55, buffer 1
        exp_byte = 8'h55;
        q_base = wr_q.size();
        send(frame_px, 8'h00, 8'hFF, 8'h01, 1'b1);
        tick();
        check("b_w0_en", 32'(wr_q[q_base].en), 32'b001);
        check("b_w0_addr", 32'(wr_q[q_base].addr), 32'h8000);
        check("b_w0_data", 32'(wr_q[q_base].data), 32'h55);
        check("b_w1_addr", 32'(wr_q[q_base + 1].addr), 32'h8001);
        check("b_w2_en", 32'(wr_q[q_base + 2].en), 32'b010);
        check("b_w2_addr", 32'(wr_q[q_base + 2].addr), 32'h8000);
        check("b_w4_en", 32'(wr_q[q_base + 4].en), 32'b100);
        check("b_w6_addr", 32'(wr_q[q_base + 6].addr), 32'h8002);
        check("b_last_addr", 32'(wr_q[wr_q.size() - 1].addr), 32'h8007);
        check("b_img", 32'(image_number), 32'd2);
        check("b_ferr", 32'(frame_error), 32'd0);

        // Short frame: SOF reinserted after 100 pixels, then a full frame in buffer 0
        exp_byte = 8'h00;
        send(100, 8'h00, 8'h00, 8'h80, 1'b1);
        tick();
        check("s_img_hold", 32'(image_number), 32'd2);
        exp_byte = 8'hFF;
        q_base = wr_q.size();
        send(frame_px, 8'hC0, 8'h80, 8'h80, 1'b1);
        tick();
        check("s_count", 32'(wr_q.size() - q_base), 32'd24);
        check("s_first_addr", 32'(wr_q[q_base].addr), 32'h0000);
        check("s_last_addr", 32'(wr_q[wr_q.size() - 1].addr), 32'h0007);
        check("s_img", 32'(image_number), 32'd3);
        check("s_ferr", 32'(frame_error), 32'(exp_ferr));

        // Asynchronous reset mid-frame
        send(50, 8'h80, 8'h80, 8'h80, 1'b1);
        check("m_addr_before", 32'(wr_address), 32'h8001);
        #2;
        pclk_reset_n = 1'b0;
        #1;
        check("m_rst_addr", 32'(wr_address), 32'h0);
        check("m_rst_data", 32'(wr_data), 32'h0);
        check("m_rst_img", 32'(image_number), 32'd0);
        check("m_rst_ready", 32'(pix_ready), 32'd0);
        check("m_rst_ferr", 32'(frame_error), 32'd0);
        @(negedge pclk);
        pclk_reset_n = 1'b1;
        q_base = wr_q.size();
        send(10, 8'hFF, 8'hFF, 8'h00, 1'b0);
        tick();
        check("m_drop_count", 32'(wr_q.size() - q_base), 32'd0);
        check("m_drop_img", 32'(image_number), 32'd0);

        // 16 frames of 0x7F at threshold 0x80 -> zeros, image_number wraps
        exp_byte = 8'h00;
        q_base = wr_q.size();
        for (int f = 0; f < 16; f++) begin
            send(frame_px, 8'h7F, 8'h7F, 8'h80, 1'b1);
            tick();
            if (f == 0) begin
                check("w_first_addr", 32'(wr_q[q_base].addr), 32'h0000);
                check("w_img1", 32'(image_number), 32'd1);
            end
        end
        check("w_img_wrap", 32'(image_number), 32'd0);
        check("w_last_addr", 32'(wr_q[wr_q.size() - 1].addr), 32'h8007);
        check("w_count", 32'(wr_q.size() - q_base), 32'd384);

        // Frame 17: 0xFF at threshold 0xFF -> ones, back in buffer 0
        exp_byte = 8'hFF;
        q_base = wr_q.size();
        send(frame_px, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        tick();
        check("f17_first_addr", 32'(wr_q[q_base].addr), 32'h0000);
        check("f17_img", 32'(image_number), 32'd1);

        check("byte_values", 32'(bad_cnt), 32'd0);
        check("one_hot_en", 32'(multi_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
